// File: rtl/temp_sens_pkg.sv
// temp_sens_pkg: shared scheduler state encoding and default widths
package temp_sens_pkg;
  localparam int PERIOD_W_DEF = 24;
  localparam int DATA_W_DEF = 16;
  localparam int TIMEOUT_DEF = 1000;
  typedef enum logic [1:0] {IDLE, WAIT, START, BUSY} state_e;
endpackage

// File: rtl/temp_sample_sched_if.sv
// temp_sample_sched_if: SPI read request/response handshake between scheduler and SPI master
interface temp_sample_sched_if import temp_sens_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic spi_start;
  logic spi_done;
  logic [DATA_W-1:0] spi_rx_data;
  modport master (output spi_start, input spi_done, input spi_rx_data);
  modport slave (input spi_start, output spi_done, output spi_rx_data);
endinterface

// File: rtl/interval_timer.sv
// interval_timer: free-running sample interval counter, period latched only at reload
module interval_timer import temp_sens_pkg::*; #(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d, per_q, per_d, last;
  // period 0 collapses to 1 so the terminal count is never unreachable
  always_comb begin
    last = (per_q == '0) ? '0 : per_q - 1'b1;
    tick = !clear && cnt_q == last;
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    per_d = (clear || tick) ? period : per_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end
endmodule

// File: rtl/temp_sample_sched.sv
// temp_sample_sched: periodic SPI temperature read scheduler with timeout and overrun detection
module temp_sample_sched import temp_sens_pkg::*; #(
  parameter int PERIOD_W    = PERIOD_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_err,
  temp_sample_sched_if.master spi,
  output logic [DATA_W-1:0]   temp_data,
  output logic                temp_valid,
  output logic [15:0]         sample_cnt,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_overrun
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic valid_q, valid_d, terr_q, terr_d, oerr_q, oerr_d;
  logic tick, capture, expire, reading;
  interval_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .period (period),
    .tick   (tick)
  );
  always_comb begin
    reading = state_q == START || state_q == BUSY;
    capture = state_q == BUSY && spi.spi_done;
    expire = state_q == BUSY && !spi.spi_done && to_q == TO_W'(TIMEOUT_CYC - 1);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? WAIT : IDLE;
      WAIT:    state_d = !enable ? IDLE : tick ? START : WAIT;
      START:   state_d = BUSY;
      BUSY:    state_d = (capture || expire) ? (enable ? WAIT : IDLE) : BUSY;
      default: state_d = IDLE;
    endcase
    to_d = state_q == START ? '0 : state_q == BUSY ? to_q + 1'b1 : to_q;
    data_d = capture ? spi.spi_rx_data : data_q;
    valid_d = capture;
    cnt_d = capture ? cnt_q + 16'd1 : cnt_q;
    terr_d = (terr_q && !clr_err) || expire;
    oerr_d = (oerr_q && !clr_err) || (tick && reading);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      to_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      oerr_q  <= oerr_d;
    end
  end
  assign spi.spi_start = state_q == START;
  assign busy = reading;
  assign temp_data = data_q;
  assign temp_valid = valid_q;
  assign sample_cnt = cnt_q;
  assign err_timeout = terr_q;
  assign err_overrun = oerr_q;
endmodule

// File: tb/tb_temp_sample_sched.sv
// tb_temp_sample_sched: table-driven scheduler scenarios plus reset, clear and enable corner sequences
module tb_temp_sample_sched;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clr_err = 1'b0;
  logic [23:0] period = '0;
  logic [15:0] temp_data, sample_cnt;
  logic temp_valid, busy, err_timeout, err_overrun;
  logic [15:0] rx = '0;
  int cyc = 0, errs = 0, checks = 0, lat = 0, k = 0, nvalid = 0, t_en = 0, w = 0;
  int starts[$];

  typedef struct {
    int per; int lat; int data; int first; int gap; int ovr; int to; int cnt; int ed;
  } vec_t;
  vec_t v[6];

  temp_sample_sched_if #(.DATA_W(16)) ifc ();
  temp_sample_sched #(.PERIOD_W(24), .DATA_W(16), .TIMEOUT_CYC(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period      (period),
    .clr_err     (clr_err),
    .spi         (ifc),
    .temp_data   (temp_data),
    .temp_valid  (temp_valid),
    .sample_cnt  (sample_cnt),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI master model: answers lat cycles after a start, never when lat is 0
  always @(negedge clk) begin
    ifc.spi_done = 1'b0;
    if (k > 0) begin
      k--;
      ifc.spi_done = (k == 0);
    end
    if (ifc.spi_start && lat > 0) k = lat;
    ifc.spi_rx_data = rx;
  end

  always @(negedge clk) begin
    if (ifc.spi_start) starts.push_back(cyc);
    if (temp_valid) begin
      nvalid++;
      chk("valid_data", int'(temp_data), int'(rx));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    clr_err = 1'b0;
    step(2);
    rst = 1'b0;
    starts.delete();
    nvalid = 0;
  endtask

  task automatic wait_starts(input int n);
    w = 0;
    while (starts.size() < n && w < 500) begin
      step(1);
      w++;
    end
    chk("start_seen", int'(starts.size() >= n), 1);
  endtask

  initial begin
    v[0] = '{10, 4, 'h1234, 11, 10, 0, 0, 3, 'h1234};
    v[1] = '{ 5, 7, 'hBEEF,  6, 10, 1, 0, 3, 'hBEEF};
    v[2] = '{30, 0, 'h4321, 31, 30, 0, 1, 0, 'h0000};
    v[3] = '{ 0, 2, 'h00A5,  2,  4, 1, 0, 3, 'h00A5};
    v[4] = '{ 1, 1, 'h0F0F,  2,  3, 1, 0, 3, 'h0F0F};
    v[5] = '{ 3, 1, 'h7FFF,  4,  3, 0, 0, 3, 'h7FFF};

    do_reset();
    chk("rst_temp_data", int'(temp_data), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    chk("rst_outputs", int'({busy, ifc.spi_start, temp_valid, err_timeout, err_overrun}), 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      period = 24'(v[i].per);
      lat = v[i].lat;
      rx = 16'(v[i].data);
      enable = 1'b1;
      t_en = cyc;
      wait_starts(3);
      enable = 1'b0;
      step(40);
      if (starts.size() >= 3) begin
        chk($sformatf("v%0d_first", i), starts[0] - t_en, v[i].first);
        chk($sformatf("v%0d_gap1", i), starts[1] - starts[0], v[i].gap);
        chk($sformatf("v%0d_gap2", i), starts[2] - starts[1], v[i].gap);
      end
      chk($sformatf("v%0d_nstarts", i), starts.size(), 3);
      chk($sformatf("v%0d_sample_cnt", i), int'(sample_cnt), v[i].cnt);
      chk($sformatf("v%0d_nvalid", i), nvalid, v[i].cnt);
      chk($sformatf("v%0d_temp_data", i), int'(temp_data), v[i].ed);
      chk($sformatf("v%0d_overrun", i), int'(err_overrun), v[i].ovr);
      chk($sformatf("v%0d_timeout", i), int'(err_timeout), v[i].to);
      chk($sformatf("v%0d_busy_idle", i), int'(busy), 0);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      step(1);
      chk($sformatf("v%0d_clr_flags", i), int'({err_timeout, err_overrun}), 0);
    end

    // reset during an outstanding read; the late done must be ignored
    do_reset();
    period = 24'd10;
    lat = 4;
    rx = 16'h5555;
    enable = 1'b1;
    wait_starts(1);
    step(1);
    chk("rstbusy_busy", int'(busy), 1);
    rst = 1'b1;
    enable = 1'b0;
    step(1);
    rst = 1'b0;
    step(6);
    chk("rstbusy_temp_data", int'(temp_data), 0);
    chk("rstbusy_sample_cnt", int'(sample_cnt), 0);
    chk("rstbusy_nvalid", nvalid, 0);
    chk("rstbusy_busy_low", int'(busy), 0);
    chk("rstbusy_nstarts", starts.size(), 1);

    // clear coinciding with an overrun set keeps the flag
    do_reset();
    period = '0;
    lat = 2;
    enable = 1'b1;
    step(2);
    chk("clrset_in_start", int'(ifc.spi_start), 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("clrset_overrun", int'(err_overrun), 1);
    enable = 1'b0;
    step(10);

    // enable dropped while waiting: no start ever issued
    do_reset();
    period = 24'd10;
    lat = 4;
    enable = 1'b1;
    step(3);
    enable = 1'b0;
    step(20);
    chk("waitdrop_nstarts", starts.size(), 0);
    chk("waitdrop_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
